// File: rtl/hm01b0_frame_stats_tx.sv
// hm01b0_frame_stats_tx: per-frame pixel/line/frame statistics from HM01B0 timing, sent as an ASCII hex line over a byte UART.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   pixclk     camera pixel clock (asynchronous, <= clock/4)
//   hsync      camera line-valid (asynchronous, active level HSYNC_ACT)
//   vsync      camera frame-valid (asynchronous, active level VSYNC_ACT)
//   enable     1 = a report is started at each frame end
//   tx_data    ASCII byte to uart_tx
//   tx_strobe  one-cycle data_valid pulse to uart_tx
//   tx_busy    uart_tx busy
//   overrun    one-cycle pulse when a frame end arrives while a report is in flight
//   pix_sat    pixel counter saturated in the last reported frame
module hm01b0_frame_stats_tx #(
    parameter int   PIX_W       = 24,
    parameter int   LINE_W      = 16,
    parameter int   FRAME_W     = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic VSYNC_ACT   = 1'b1,
    parameter logic HSYNC_ACT   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pixclk,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       enable,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    input  logic       tx_busy,
    output logic       overrun,
    output logic       pix_sat
);
    localparam int PD = PIX_W / 4;
    localparam int LD = LINE_W / 4;
    localparam int FD = FRAME_W / 4;
    localparam int N  = PD + LD + FD + 4;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, STROBE, SETTLE, WAIT} state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] pc_sr, hs_sr, vs_sr;
    logic pc_d, hs_d, vs_d;
    logic [PIX_W-1:0] pix_cnt, snap_p;
    logic [LINE_W-1:0] line_cnt, snap_l;
    logic [FRAME_W-1:0] frame_cnt, snap_f, frame_inc;
    logic [IW-1:0] idx;
    logic sat;

    // Polarity is folded in ahead of the synchronisers so everything downstream
    // is active-high and a cleared synchroniser always reads as "inactive".
    logic hs_in, vs_in;
    assign hs_in = hsync ^ ~HSYNC_ACT;
    assign vs_in = vsync ^ ~VSYNC_ACT;

    logic pc_s, hs_s, vs_s;
    assign pc_s = pc_sr[SYNC_STAGES-1];
    assign hs_s = hs_sr[SYNC_STAGES-1];
    assign vs_s = vs_sr[SYNC_STAGES-1];

    logic pix_ev, line_ev, frame_end, start, last, adv;
    assign pix_ev    = pc_s & ~pc_d & vs_s & hs_s;
    assign line_ev   = hs_s & ~hs_d & vs_s;
    assign frame_end = vs_d & ~vs_s;
    assign frame_inc = frame_cnt + 1'b1;
    assign start     = (state == IDLE) & frame_end & enable;
    assign last      = idx == IW'(N - 1);
    assign adv       = (state == WAIT) & ~tx_busy & ~last;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    // Byte i of the report line: pixel digits, space, line digits, space, frame digits, CR, LF.
    function automatic logic [7:0] byte_at(input logic [PIX_W-1:0] p, input logic [LINE_W-1:0] l,
                                           input logic [FRAME_W-1:0] f, input int i);
        logic [7:0] b;
        if (i < PD)                 b = hex(4'(p >> (4 * (PD - 1 - i))));
        else if (i == PD)           b = 8'h20;
        else if (i < PD + LD + 1)   b = hex(4'(l >> (4 * (PD + LD - i))));
        else if (i == PD + LD + 1)  b = 8'h20;
        else if (i < N - 2)         b = hex(4'(f >> (4 * (N - 3 - i))));
        else if (i == N - 2)        b = 8'h0D;
        else                        b = 8'h0A;
        return b;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
            pc_d  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            pc_sr <= {pc_sr[SYNC_STAGES-2:0], pixclk};
            hs_sr <= {hs_sr[SYNC_STAGES-2:0], hs_in};
            vs_sr <= {vs_sr[SYNC_STAGES-2:0], vs_in};
            pc_d  <= pc_s;
            hs_d  <= hs_s;
            vs_d  <= vs_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            sat      <= 1'b0;
        end else if (!vs_s) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            if (pix_ev) pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
            if (line_ev) line_cnt <= (&line_cnt) ? line_cnt : line_cnt + 1'b1;
            sat <= sat | (pix_ev & (&pix_cnt));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tx_strobe = 1'b0;
        overrun   = frame_end & (state != IDLE);
        case (state)
            IDLE:    state_nx = start ? STROBE : IDLE;
            STROBE: begin
                tx_strobe = 1'b1;
                state_nx  = SETTLE;
            end
            SETTLE:  state_nx = WAIT;
            WAIT:    state_nx = tx_busy ? WAIT : (last ? IDLE : STROBE);
            default: state_nx = IDLE;
        endcase
    end

    // tx_data is loaded on the transition into STROBE so it is valid with the
    // strobe and holds until the next one; the first byte comes from the live counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            snap_p    <= '0;
            snap_l    <= '0;
            snap_f    <= '0;
            pix_sat   <= 1'b0;
            idx       <= '0;
            tx_data   <= 8'h00;
        end else begin
            if (frame_end) frame_cnt <= frame_inc;
            if (start) begin
                snap_p  <= pix_cnt;
                snap_l  <= line_cnt;
                snap_f  <= frame_inc;
                pix_sat <= sat;
                idx     <= '0;
                tx_data <= byte_at(pix_cnt, line_cnt, frame_inc, 0);
            end else if (adv) begin
                idx     <= idx + 1'b1;
                tx_data <= byte_at(snap_p, snap_l, snap_f, int'(idx) + 1);
            end
        end
    end
endmodule

// File: tb/tb_hm01b0_frame_stats_tx.sv
// tb_hm01b0_frame_stats_tx: scoreboard bench for hm01b0_frame_stats_tx (default, narrow-field and inverted-polarity instances).
module tb_hm01b0_frame_stats_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pc = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [2:0] en = 3'b000;
    logic [2:0] stb, busy, ovr, sat;
    logic [7:0] data [3];
    int busy_len = 0;
    int bc [3];
    int st_n [3];
    int ov_n [3];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q [3][$];
    string hx = "0123456789ABCDEF";

    always #5 clock = ~clock;

    hm01b0_frame_stats_tx dut_a (
        .clock(clock), .reset(reset), .pixclk(pc), .hsync(hs), .vsync(vs), .enable(en[0]),
        .tx_data(data[0]), .tx_strobe(stb[0]), .tx_busy(busy[0]), .overrun(ovr[0]), .pix_sat(sat[0])
    );

    hm01b0_frame_stats_tx #(.PIX_W(8), .LINE_W(4), .FRAME_W(4)) dut_b (
        .clock(clock), .reset(reset), .pixclk(pc), .hsync(hs), .vsync(vs), .enable(en[1]),
        .tx_data(data[1]), .tx_strobe(stb[1]), .tx_busy(busy[1]), .overrun(ovr[1]), .pix_sat(sat[1])
    );

    hm01b0_frame_stats_tx #(.VSYNC_ACT(1'b0), .HSYNC_ACT(1'b0)) dut_c (
        .clock(clock), .reset(reset), .pixclk(pc), .hsync(~hs), .vsync(~vs), .enable(en[2]),
        .tx_data(data[2]), .tx_strobe(stb[2]), .tx_busy(busy[2]), .overrun(ovr[2]), .pix_sat(sat[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: busy rises the cycle after a strobe and lasts busy_len cycles.
    always @(posedge clock or negedge reset)
        for (int i = 0; i < 3; i++)
            bc[i] <= !reset ? 0 : stb[i] ? busy_len : (bc[i] > 0 ? bc[i] - 1 : 0);

    always_comb for (int i = 0; i < 3; i++) busy[i] = bc[i] != 0;

    always @(negedge clock)
        for (int i = 0; i < 3; i++) begin
            if (ovr[i]) ov_n[i] <= ov_n[i] + 1;
            if (stb[i]) begin
                st_n[i] <= st_n[i] + 1;
                chk($sformatf("byte_avail%0d", i), 32'(q[i].size() > 0), 32'd1);
                if (q[i].size() > 0)
                    chk($sformatf("byte%0d_%0d", i, st_n[i]), 32'(data[i]), 32'(q[i].pop_front()));
            end
        end

    task automatic push_str(input int i, input string s);
        for (int k = 0; k < s.len(); k++) q[i].push_back(s[k]);
    endtask

    task automatic push_eol(input int i);
        q[i].push_back(8'h0D);
        q[i].push_back(8'h0A);
    endtask

    task automatic frame(input int lines, input int pix);
        vs = 1'b1;
        #200;
        for (int l = 0; l < lines; l++) begin
            hs = 1'b1;
            #200;
            for (int p = 0; p < pix; p++) begin
                pc = 1'b1;
                #40;
                pc = 1'b0;
                #40;
            end
            #100;
            hs = 1'b0;
            #200;
        end
        vs = 1'b0;
        #300;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (k < 20000 && (q[0].size() + q[1].size() + q[2].size()) != 0) begin
            @(posedge clock);
            k++;
        end
        repeat (60) @(posedge clock);
        chk({"drain_", tag}, 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int b0, b1, b2, k;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_strobe%0d", i), 32'(stb[i]), 32'd0);
            chk($sformatf("rst_data%0d", i), 32'(data[i]), 32'd0);
            chk($sformatf("rst_overrun%0d", i), 32'(ovr[i]), 32'd0);
            chk($sformatf("rst_sat%0d", i), 32'(sat[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 4x10 frame on the default and the inverted-polarity instance together
        busy_len = 20;
        en = 3'b101;
        push_str(0, "000028 0004 0001");
        push_eol(0);
        push_str(2, "000028 0004 0001");
        push_eol(2);
        b0 = st_n[0]; b1 = st_n[1]; b2 = st_n[2];
        frame(4, 10);
        drain("basic");
        chk("basic_strobes_a", 32'(st_n[0] - b0), 32'd18);
        chk("basic_strobes_b", 32'(st_n[1] - b1), 32'd0);
        chk("basic_strobes_c", 32'(st_n[2] - b2), 32'd18);
        chk("basic_sat_a", 32'(sat[0]), 32'd0);

        // narrow fields: saturation then a clean frame
        do_reset();
        en = 3'b010;
        busy_len = 3;
        push_str(1, "FF 1 1");
        push_eol(1);
        frame(1, 300);
        drain("sat");
        chk("sat_set", 32'(sat[1]), 32'd1);
        push_str(1, "05 1 2");
        push_eol(1);
        frame(1, 5);
        drain("unsat");
        chk("sat_clear", 32'(sat[1]), 32'd0);

        // frame counter wraps modulo 16
        do_reset();
        busy_len = 0;
        en = 3'b010;
        for (int f = 1; f <= 17; f++) begin
            push_str(1, "02 1 ");
            q[1].push_back(hx[f % 16]);
            push_eol(1);
            frame(1, 2);
            drain($sformatf("wrap%0d", f));
        end

        // overrun: second frame ends while the first report is still sending
        do_reset();
        busy_len = 20;
        en = 3'b001;
        b0 = ov_n[0]; b1 = ov_n[1]; b2 = ov_n[2];
        push_str(0, "000006 0002 0001");
        push_eol(0);
        frame(2, 3);
        frame(1, 1);
        drain("ovr_first");
        push_str(0, "000002 0001 0003");
        push_eol(0);
        frame(1, 2);
        drain("ovr_next");
        chk("ovr_count_a", 32'(ov_n[0] - b0), 32'd1);
        chk("ovr_count_b", 32'(ov_n[1] - b1), 32'd0);
        chk("ovr_count_c", 32'(ov_n[2] - b2), 32'd0);

        // reset asserted while byte 5 is being strobed
        do_reset();
        en = 3'b001;
        busy_len = 20;
        push_str(0, "00002");
        b0 = st_n[0];
        frame(4, 10);
        k = 0;
        while (k < 2000 && !(stb[0] && st_n[0] - b0 == 5)) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("rst_reach", 32'(st_n[0] - b0), 32'd5);
        reset = 1'b0;
        #1;
        chk("midrst_strobe", 32'(stb[0]), 32'd0);
        chk("midrst_data", 32'(data[0]), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("midrst_queue", 32'(q[0].size()), 32'd0);
        b0 = st_n[0];
        repeat (200) @(negedge clock);
        chk("midrst_quiet", 32'(st_n[0] - b0), 32'd0);
        push_str(0, "000006 0002 0001");
        push_eol(0);
        frame(2, 3);
        drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hm01b0_frame_stats_tx.md
Name: hm01b0_frame_stats_tx

Overview:
- Samples the HM01B0 parallel-interface timing signals (pixclk, hsync, vsync) in the system clock domain.
- Counts pixels, lines and frames per frame.
- At each frame end, snapshots the counts and serialises them as an ASCII hex report line into a byte-wide UART transmitter (uart_tx data_valid/busy handshake).
- Parametrised successor to the fixed 24-bit pixel-count-only reporter: configurable field widths, synchroniser depth and sync polarity; adds line and frame counts, saturation and overrun detection.

Parameters:
- PIX_W, 24, pixel-count width in bits; multiple of 4, range 4..32.
- LINE_W, 16, line-count width in bits; multiple of 4, range 4..32.
- FRAME_W, 16, frame-count width in bits; multiple of 4, range 4..32.
- SYNC_STAGES, 2, flip-flops in each input synchroniser; minimum 2.
- VSYNC_ACT, 1, active level of vsync.
- HSYNC_ACT, 1, active level of hsync.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- pixclk  in  1  camera pixel clock, asynchronous to clock.
- hsync  in  1  camera line-valid, asynchronous.
- vsync  in  1  camera frame-valid, asynchronous.
- enable  in  1  1 = reports generated; 0 = counting continues, no new report starts.
- tx_data  out  8  ASCII byte to uart_tx.
- tx_strobe  out  1  one-cycle data_valid pulse to uart_tx.
- tx_busy  in  1  uart_tx busy.
- overrun  out  1  one-cycle pulse when a frame end is dropped because a report is in flight.
- pix_sat  out  1  sticky per frame: the pixel counter saturated in the last reported frame.

Behaviour:
- Inputs pass through SYNC_STAGES-deep synchronisers, then one extra register for edge detection. The pixclk frequency must be at most clock/4; e.g. at 12 MHz clock, pixclk ≤ 3 MHz.
- Pixel and line events:
  - pixel event: synchronised pixclk rising edge while vsync and hsync are both at their active levels.
  - line event: hsync edge into its active level while vsync is active.
- pix_cnt: +1 per pixel event; saturates at all-ones (no wrap) and sets an internal sat flag. line_cnt follows the same rule, without a flag output.
- While vsync is inactive, pix_cnt, line_cnt and sat are held at 0.
- Frame end is the vsync edge out of its active level. In that cycle:
  - frame_cnt increments, wrapping modulo 2^FRAME_W.
  - If the FSM is IDLE and enable=1: snapshot pix_cnt, line_cnt, the post-increment frame_cnt, and sat → pix_sat. pix_cnt is sampled before any same-cycle pixel event, which cannot occur because vsync is inactive.
  - Otherwise, if the FSM is not IDLE: snapshot unchanged, overrun=1 for that cycle.
  - If enable=0 while the FSM is IDLE: frame silently skipped, no overrun.
- Report format: PIX_W/4 hex digits, space (0x20), LINE_W/4 digits, space, FRAME_W/4 digits, 0x0D, 0x0A.
  - Total N = PIX_W/4 + LINE_W/4 + FRAME_W/4 + 4 bytes.
  - Digits are MSB nibble first, uppercase '0'-'9','A'-'F'.
- FSM states: IDLE, STROBE, SETTLE, WAIT.
  - IDLE → STROBE on snapshot; idx=0.
  - STROBE: tx_strobe=1 for exactly one cycle; tx_data = byte[idx] and stays stable from STROBE until the next STROBE. → SETTLE.
  - SETTLE: one cycle (uart_tx raises busy the cycle after data_valid). → WAIT.
  - WAIT: hold while tx_busy=1. On tx_busy=0: if idx==N-1 → IDLE, else idx+1 → STROBE.
- Latency: first tx_strobe occurs 1 cycle after the detected frame-end cycle.
- The snapshot is immutable while the FSM is not IDLE.
- enable deassertion mid-report has no effect; the report completes.
- Reset values: tx_strobe=0, overrun=0, pix_sat=0, tx_data=0x00, FSM=IDLE, all counters and snapshots 0, synchronisers 0.
- Reset low mid-report aborts the report immediately; tx_strobe never glitches high during reset.

Test Plan:
- Defaults; frame of 4 lines × 10 pixels; tx_busy held high 20 cycles after each strobe → byte stream "000028 0004 0001\r\n" (18 bytes); exactly 18 tx_strobe pulses; FSM returns to IDLE.
- PIX_W=8, LINE_W=4, FRAME_W=4; frame of 300 pixels in 1 line → "FF 1 1\r\n", pix_sat=1. A following 5-pixel frame → "05 1 2\r\n", pix_sat=0.
- FRAME_W=4; 17 frames with enable=1 and an idle UART → the 16th report's frame field is "0", the 17th is "1".
- Second frame ends while the first report is still sending (tx_busy long) → overrun pulses once; the first report is transmitted intact; the next report shows frame_cnt incremented by 2.
- VSYNC_ACT=0, HSYNC_ACT=0 with inverted stimulus of scenario 1 → identical byte stream.
- Reset driven low during byte 5 → tx_strobe low within the same cycle. After release with no new frame: no strobes. The next 2×3 frame reports "000006 0002 0001\r\n".
